spi_master_frame: RTL and testbench

Frame-generating SPI master that drives the `SPI_slave` ALU block; it sits directly upstream of the slave and shares its `clk_arduino` clock. On a `start` request it latches two operands and an operator, then sends them on `MOSI` with `CS` low: a handshake bit, the payload, one turnaround cycle, and then a 4-bit result read back from `MISO`. It stands in for the Arduino master in FPGA-only builds and provides the reusable stimulus source for slave-level benches.

---
 rtl/spi_pkg.sv | 32 +++
 rtl/spi_shift_reg.sv | 27 ++
 rtl/spi_master_frame.sv | 151 +++++++++++++++
 tb/tb_spi_master_frame.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared state type, default widths and frame-length helpers for spi_master_frame.
// Optional parity (one bit each direction) is enabled by defining SPI_MASTER_PARITY_EN.
package spi_pkg;

    typedef enum logic [2:0] {IDLE, HS, SEND, TURN, RECV, DONE} spi_state_t;

    localparam int unsigned OPND_W_DEF = 4;
    localparam int unsigned OPR_W_DEF  = 2;
    localparam int unsigned RES_W_DEF  = 4;

`ifdef SPI_MASTER_PARITY_EN
    localparam int unsigned PAR_BITS = 1;
`else
    localparam int unsigned PAR_BITS = 0;
`endif

    function automatic int unsigned payload_len(input int unsigned opnd_w,
                                                input int unsigned opr_w);
        return 2 * opnd_w + opr_w;
    endfunction

    localparam int unsigned PAYLOAD_LEN = payload_len(OPND_W_DEF, OPR_W_DEF);

    // Cycles with CS low: handshake, payload, tx parity, turnaround, result, rx parity.
    function automatic int unsigned frame_len(input int unsigned opnd_w,
                                              input int unsigned opr_w,
                                              input int unsigned res_w,
                                              input int unsigned par_bits);
        return payload_len(opnd_w, opr_w) + res_w + 2 * par_bits + 2;
    endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// LSB-first shift register: parallel load / serial out for TX, serial in / parallel out for RX.
module spi_shift_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk_arduino,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         shift_en,
    input  logic         serial_in,
    output logic         serial_out,
    output logic [W-1:0] q
);

    always_ff @(posedge clk_arduino) begin
        if (!reset) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (shift_en) begin
            q <= {serial_in, q[W-1:1]};
        end
    end

    assign serial_out = q[0];

endmodule

// File: rtl/spi_master_frame.sv
// SPI frame master for the SPI_slave ALU: handshake, operand/operator payload, turnaround, result readback.
// Define SPI_MASTER_PARITY_EN to append an even-parity bit to the payload and check one on the result.
module spi_master_frame
    import spi_pkg::*;
#(
    parameter int unsigned OPND_W = OPND_W_DEF,
    parameter int unsigned OPR_W  = OPR_W_DEF,
    parameter int unsigned RES_W  = RES_W_DEF
) (
    input  logic              clk_arduino,
    input  logic              reset,
    input  logic              start,
    input  logic [OPND_W-1:0] operand_1,
    input  logic [OPND_W-1:0] operand_2,
    input  logic [OPR_W-1:0]  operator,
    input  logic              MISO,
    output logic              MOSI,
    output logic              CS,
    output logic              busy,
    output logic              done,
    output logic [RES_W-1:0]  result,
    output logic              parity_err
);

    localparam int unsigned P     = payload_len(OPND_W, OPR_W);
    localparam int unsigned TX_W  = P + PAR_BITS;
    localparam int unsigned RX_W  = RES_W + PAR_BITS;
    localparam int unsigned CNT_W = $clog2(frame_len(OPND_W, OPR_W, RES_W, PAR_BITS));

    spi_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic [P-1:0]      payload;
    logic [TX_W-1:0]   tx_load_val;
    logic [TX_W-1:0]   tx_q_unused;
    logic              tx_bit;
    logic [RX_W-1:0]   rx_q;
    logic              rx_sout_unused;
    logic              accept;
    logic              tx_last;
    logic              rx_last;
    logic              tx_shift;
    logic              rx_shift;

    assign payload = {operator, operand_2, operand_1};
`ifdef SPI_MASTER_PARITY_EN
    assign tx_load_val = {^payload, payload};
`else
    assign tx_load_val = payload;
`endif

    // DONE has busy low, so a start there begins the next frame immediately.
    assign accept   = start && (state == IDLE || state == DONE);
    assign tx_last  = (cnt == CNT_W'(TX_W - 1));
    assign rx_last  = (cnt == CNT_W'(RX_W - 1));
    assign tx_shift = (state == HS) || (state == SEND && !tx_last);
    // The edge leaving TURN captures the first result bit.
    assign rx_shift = (state == TURN) || (state == RECV && !rx_last);

    spi_shift_reg #(.W(TX_W)) u_tx (
        .clk_arduino (clk_arduino),
        .reset       (reset),
        .load        (accept),
        .load_val    (tx_load_val),
        .shift_en    (tx_shift),
        .serial_in   (1'b0),
        .serial_out  (tx_bit),
        .q           (tx_q_unused)
    );

    spi_shift_reg #(.W(RX_W)) u_rx (
        .clk_arduino (clk_arduino),
        .reset       (reset),
        .load        (1'b0),
        .load_val    ('0),
        .shift_en    (rx_shift),
        .serial_in   (MISO),
        .serial_out  (rx_sout_unused),
        .q           (rx_q)
    );

    always_ff @(posedge clk_arduino) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            CS     <= 1'b1;
            MOSI   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        state <= HS;
                        CS    <= 1'b0;
                        MOSI  <= 1'b1;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                HS: begin
                    state <= SEND;
                    MOSI  <= tx_bit;
                    cnt   <= '0;
                end
                SEND: begin
                    if (tx_last) begin
                        state <= TURN;
                        MOSI  <= 1'b0;
                    end else begin
                        MOSI <= tx_bit;
                        cnt  <= cnt + 1'b1;
                    end
                end
                TURN: begin
                    state <= RECV;
                    cnt   <= '0;
                end
                RECV: begin
                    if (rx_last) begin
                        state  <= DONE;
                        CS     <= 1'b1;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= rx_q[RES_W-1:0];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SPI_MASTER_PARITY_EN
    always_ff @(posedge clk_arduino) begin
        if (!reset) begin
            parity_err <= 1'b0;
        end else if (state == RECV && rx_last) begin
            parity_err <= ^rx_q;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_master_frame.sv
// Scoreboard bench for spi_master_frame: randomized frames against a bit-list reference model.
module tb_spi_master_frame;
    import spi_pkg::*;

    localparam int unsigned OPND_W = 4;
    localparam int unsigned OPR_W  = 2;
    localparam int unsigned RES_W  = 4;
`ifdef SPI_MASTER_PARITY_EN
    localparam int unsigned PAR = 1;
`else
    localparam int unsigned PAR = 0;
`endif
    localparam int unsigned P    = 2 * OPND_W + OPR_W;
    localparam int unsigned TX_W = P + PAR;
    localparam int unsigned RX_W = RES_W + PAR;
    localparam int unsigned L    = frame_len(OPND_W, OPR_W, RES_W, PAR);

    typedef struct {
        logic [31:0]      mosi;
        int unsigned      mlen;
        logic [RES_W-1:0] res;
        logic             perr;
    } exp_t;

    logic              clk;
    logic              reset;
    logic              start;
    logic [OPND_W-1:0] operand_1;
    logic [OPND_W-1:0] operand_2;
    logic [OPR_W-1:0]  operator;
    logic              MISO;
    logic              MOSI;
    logic              CS;
    logic              busy;
    logic              done;
    logic [RES_W-1:0]  result;
    logic              parity_err;

    exp_t        sb[$];
    int unsigned n_chk;
    int unsigned n_fail;
    bit          stim_done;

    spi_master_frame #(.OPND_W(OPND_W), .OPR_W(OPR_W), .RES_W(RES_W)) dut (
        .clk_arduino (clk),
        .reset       (reset),
        .start       (start),
        .operand_1   (operand_1),
        .operand_2   (operand_2),
        .operator    (operator),
        .MISO        (MISO),
        .MOSI        (MOSI),
        .CS          (CS),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .parity_err  (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Issue one frame; expected bits come straight from the serial frame definition.
    task automatic do_frame(input logic [OPND_W-1:0] a, input logic [OPND_W-1:0] b,
                            input logic [OPR_W-1:0] o, input logic [31:0] miso_bits,
                            input int unsigned poke, input bit hold);
        exp_t        e;
        int unsigned ones;
        int unsigned k;
        e.mosi = '0;
        ones   = 0;
        k      = 1;
        e.mosi[0] = 1'b1;
        for (int i = 0; i < OPND_W; i++) begin e.mosi[k] = a[i]; if (a[i]) ones++; k++; end
        for (int i = 0; i < OPND_W; i++) begin e.mosi[k] = b[i]; if (b[i]) ones++; k++; end
        for (int i = 0; i < OPR_W;  i++) begin e.mosi[k] = o[i]; if (o[i]) ones++; k++; end
        if (PAR == 1) e.mosi[k] = ones[0];
        e.mlen = TX_W + 2;
        e.res  = miso_bits[RES_W-1:0];
        ones   = 0;
        for (int i = 0; i < RX_W; i++) if (miso_bits[i]) ones++;
        e.perr = (PAR == 1) ? ones[0] : 1'b0;

        @(negedge clk);
        operand_1 = a;
        operand_2 = b;
        operator  = o;
        start     = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        for (int c = 1; c <= int'(L); c++) begin
            @(negedge clk);
            start     = hold || (c == int'(poke));
            operand_1 = OPND_W'($urandom);
            operand_2 = OPND_W'($urandom);
            operator  = OPR_W'($urandom);
            if (c >= int'(TX_W) + 2 && c < int'(TX_W + 2 + RX_W))
                MISO = miso_bits[c - int'(TX_W) - 2];
            else
                MISO = 1'($urandom);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge and pops the scoreboard on done.
    logic [31:0]      cap;
    int unsigned      cs_cnt;
    logic [RES_W-1:0] model_res;
    logic             model_perr;
    bit               prev_done;
    int unsigned      drain;

    initial begin
        cap = '0; cs_cnt = 0; model_res = '0; model_perr = 1'b0; prev_done = 1'b0; drain = 0;
    end

    always @(posedge clk) begin
        exp_t        e;
        logic [31:0] mask;
        #1;
        if (!reset) begin
            chk("rst_cs", 32'(CS), 32'd1);
            chk("rst_mosi", 32'(MOSI), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_result", 32'(result), 32'd0);
            chk("rst_parity_err", 32'(parity_err), 32'd0);
            model_res  = '0;
            model_perr = 1'b0;
            cs_cnt     = 0;
            prev_done  = 1'b0;
        end else begin
            chk("busy_vs_cs", 32'(busy), 32'(!CS));
            if (prev_done) chk("done_single_cycle", 32'(done), 32'd0);
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'(sb.size()));
                end else begin
                    e    = sb.pop_front();
                    mask = (32'd1 << e.mlen) - 32'd1;
                    chk("result", 32'(result), 32'(e.res));
                    chk("parity_err", 32'(parity_err), 32'(e.perr));
                    chk("cs_low_cycles", cs_cnt, L);
                    chk("cs_high_at_done", 32'(CS), 32'd1);
                    chk("mosi_frame", cap & mask, e.mosi & mask);
                    model_res  = e.res;
                    model_perr = e.perr;
                end
            end else begin
                chk("result_hold", 32'(result), 32'(model_res));
                chk("parity_err_hold", 32'(parity_err), 32'(model_perr));
            end
            if (!CS) begin
                if (cs_cnt < 32) cap[cs_cnt] = MOSI;
                cs_cnt++;
            end else begin
                cs_cnt = 0;
            end
            prev_done = done;
        end
        if (stim_done) begin
            drain++;
            if (sb.size() == 0 || drain > 4 * L) begin
                chk("scoreboard_empty", 32'(sb.size()), 32'd0);
                $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
                $finish;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: summary not reached within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] mb;
        int unsigned gap;
        int unsigned poke;
        n_chk = 0; n_fail = 0; stim_done = 1'b0;
        reset = 1'b0; start = 1'b0; MISO = 1'b0;
        operand_1 = '0; operand_2 = '0; operator = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Directed: 3/5/01 with result 8; parity bit 0 then 1 in the second frame.
        do_frame(4'h3, 4'h5, 2'b01, 32'b0_1000, 0, 1'b0);
        repeat (2) @(negedge clk);
        do_frame(4'h3, 4'h5, 2'b01, 32'b1_1000, 5, 1'b0);
        repeat (1) @(negedge clk);

        for (int n = 0; n < 20; n++) begin
            mb   = $urandom;
            poke = ($urandom_range(1, 0) == 1) ? $urandom_range(L - 1, 1) : 0;
            gap  = $urandom_range(3, 0);
            do_frame(OPND_W'($urandom), OPND_W'($urandom), OPR_W'($urandom), mb, poke, 1'b0);
            repeat (gap) @(negedge clk);
        end

        // start held high: frames run back-to-back through the DONE cycle.
        for (int n = 0; n < 4; n++)
            do_frame(OPND_W'($urandom), OPND_W'($urandom), OPR_W'($urandom), $urandom, 0, 1'b1);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);

        // Abort: reset sampled at the edge that would present payload bit 4.
        operand_1 = 4'hA; operand_2 = 4'h6; operator = 2'b11; start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 5) reset = 1'b0;
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (L + 4) @(negedge clk);

        do_frame(4'hF, 4'h0, 2'b10, 32'b1_0110, 0, 1'b0);
        stim_done = 1'b1;
    end

endmodule
